psram_arb: RTL and testbench

PSRAM_ARB -- requirements
Module: psram_arb

---
 rtl/psram_arb_pkg.sv | 14 +
 rtl/psram_arb_if.sv | 22 ++
 rtl/psram_arb_rr2.sv | 31 +++
 rtl/psram_arb.sv | 132 +++++++++++++
 tb/tb_psram_arb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_arb_pkg.sv
// Shared constants for the PSRAM arbiter.
// FSM encodings and default strobe width.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int WAIT_CYC_DEF = 2;

endpackage

// File: rtl/psram_arb_if.sv
// Byte-wide request port into the PSRAM arbiter.
// master = requester side, slave = arbiter side.
interface psram_arb_if #(
  parameter int ADDR_W = 23
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] a;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              ack;

  modport master (
    output req, we, a, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, a, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/psram_arb_rr2.sv
// Two-way round-robin grant with last-grant pointer.
// Pointer resets to port 1 so port 0 wins the first tie.
module arb_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i == 2'b11)
        gnt_o = ptr_q ? 2'b01 : 2'b10;
      else
        gnt_o = req_i;
      if (|req_i)
        ptr_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/psram_arb.sv
// Two-port byte arbiter onto an async 16-bit PSRAM.
// Strobes decode straight from the state register.
module psram_arb
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W   = 23,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  psram_arb_if.slave        m0,
  psram_arb_if.slave        m1,
  output logic [ADDR_W-2:0] ram_a_o,
  input  logic [15:0]       ram_din_i,
  output logic [15:0]       ram_dout_o,
  output logic              ram_dq_oe_o,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o,
  output logic              ram_lb_n_o,
  output logic              ram_ub_n_o,
  output logic              ram_zz_n_o
);

  localparam logic [3:0] WAIT_L = 4'(WAIT_CYC);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [7:0]        wd_q, wd_d;
  logic [7:0]        rd0_q, rd0_d;
  logic [7:0]        rd1_q, rd1_d;
  logic [7:0]        rbyte;
  logic [1:0]        gnt;
  logic              idle, busy;

  assign idle = (state_q == ST_IDLE);
  assign busy = (state_q == ST_SETUP) ||
                (state_q == ST_ACCESS);

  arb_rr2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({m1.req, m0.req}),
    .en_i  (idle),
    .gnt_o (gnt)
  );

  assign rbyte = a_q[0] ? ram_din_i[15:8]
                        : ram_din_i[7:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          sel_d   = gnt[1];
          we_d    = gnt[1] ? m1.we    : m0.we;
          a_d     = gnt[1] ? m1.a     : m0.a;
          wd_d    = gnt[1] ? m1.wdata : m0.wdata;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = WAIT_L;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_DONE;
          // Capture on the edge closing the last strobe cycle
          if (!we_q) begin
            if (sel_q) rd1_d = rbyte;
            else       rd0_d = rbyte;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign ram_a_o     = a_q[ADDR_W-1:1];
  assign ram_dout_o  = {wd_q, wd_q};
  assign ram_dq_oe_o = we_q && !idle;
  assign ram_ce_n_o  = !busy;
  assign ram_oe_n_o  = !((state_q == ST_ACCESS) && !we_q);
  assign ram_we_n_o  = !((state_q == ST_ACCESS) && we_q);
  assign ram_lb_n_o  = !(busy && !a_q[0]);
  assign ram_ub_n_o  = !(busy && a_q[0]);
  assign ram_zz_n_o  = 1'b1;

  assign m0.ack   = (state_q == ST_DONE) && !sel_q;
  assign m1.ack   = (state_q == ST_DONE) && sel_q;
  assign m0.rdata = rd0_q;
  assign m1.rdata = rd1_q;

endmodule

// File: tb/tb_psram_arb.sv
// Directed bench for psram_arb with a small PSRAM model.
// Extra instances cover WAIT_CYC = 1 and 15.
module tb_psram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psram_arb_if #(.ADDR_W(23)) u_m0 ();
  psram_arb_if #(.ADDR_W(23)) u_m1 ();
  psram_arb_if #(.ADDR_W(23)) u_a1 ();
  psram_arb_if #(.ADDR_W(23)) u_b1 ();
  psram_arb_if #(.ADDR_W(23)) u_a15 ();
  psram_arb_if #(.ADDR_W(23)) u_b15 ();

  logic [21:0] ram_a;
  logic [15:0] ram_din, ram_dout;
  logic ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n;
  logic ram_lb_n, ram_ub_n, ram_zz_n;

  logic [21:0] x1_a, x15_a;
  logic [15:0] x1_do, x15_do;
  logic [7:0]  x1_s, x15_s;

  psram_arb #(.ADDR_W(23), .WAIT_CYC(2)) dut (
    .clk(clk), .rst(rst), .m0(u_m0), .m1(u_m1),
    .ram_a_o(ram_a), .ram_din_i(ram_din),
    .ram_dout_o(ram_dout), .ram_dq_oe_o(ram_dq_oe),
    .ram_ce_n_o(ram_ce_n), .ram_oe_n_o(ram_oe_n),
    .ram_we_n_o(ram_we_n), .ram_lb_n_o(ram_lb_n),
    .ram_ub_n_o(ram_ub_n), .ram_zz_n_o(ram_zz_n)
  );

  psram_arb #(.ADDR_W(23), .WAIT_CYC(1)) dut_w1 (
    .clk(clk), .rst(rst), .m0(u_a1), .m1(u_b1),
    .ram_a_o(x1_a), .ram_din_i(16'h0000),
    .ram_dout_o(x1_do), .ram_dq_oe_o(x1_s[0]),
    .ram_ce_n_o(x1_s[1]), .ram_oe_n_o(x1_s[2]),
    .ram_we_n_o(x1_s[3]), .ram_lb_n_o(x1_s[4]),
    .ram_ub_n_o(x1_s[5]), .ram_zz_n_o(x1_s[6])
  );

  psram_arb #(.ADDR_W(23), .WAIT_CYC(15)) dut_w15 (
    .clk(clk), .rst(rst), .m0(u_a15), .m1(u_b15),
    .ram_a_o(x15_a), .ram_din_i(16'h0000),
    .ram_dout_o(x15_do), .ram_dq_oe_o(x15_s[0]),
    .ram_ce_n_o(x15_s[1]), .ram_oe_n_o(x15_s[2]),
    .ram_we_n_o(x15_s[3]), .ram_lb_n_o(x15_s[4]),
    .ram_ub_n_o(x15_s[5]), .ram_zz_n_o(x15_s[6])
  );

  assign x1_s[7]  = 1'b0;
  assign x15_s[7] = 1'b0;

  // PSRAM model: byte-lane writes while ce_n and we_n are low
  logic [15:0] mem [256];
  logic        din_ovr_en = 1'b0;
  logic [15:0] din_ovr = 16'h0000;

  assign ram_din = din_ovr_en ? din_ovr : mem[ram_a[7:0]];

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) begin
      if (!ram_lb_n) mem[ram_a[7:0]][7:0]  <= ram_dout[7:0];
      if (!ram_ub_n) mem[ram_a[7:0]][15:8] <= ram_dout[15:8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          lat, we_lo, oe_lo, oth_ack;
  logic [21:0] s_a;
  logic [15:0] s_dout;
  logic        s_lb, s_ub, s_dq, s_ce, s_dqdone;

  task automatic txn(input bit p, input bit w,
                     input logic [22:0] a,
                     input logic [7:0] wd);
    bit got;
    @(posedge clk); #1;
    if (!p) begin
      u_m0.req = 1'b1; u_m0.we = w;
      u_m0.a = a; u_m0.wdata = wd;
    end else begin
      u_m1.req = 1'b1; u_m1.we = w;
      u_m1.a = a; u_m1.wdata = wd;
    end
    @(posedge clk);
    got = 1'b0; lat = 0; we_lo = 0;
    oe_lo = 0; oth_ack = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        s_a = ram_a; s_dout = ram_dout;
        s_lb = ram_lb_n; s_ub = ram_ub_n;
        s_dq = ram_dq_oe; s_ce = ram_ce_n;
      end
      if (!ram_we_n) we_lo++;
      if (!ram_oe_n) oe_lo++;
      if (p ? u_m0.ack : u_m1.ack) oth_ack++;
      if (p ? u_m1.ack : u_m0.ack) begin
        got = 1'b1; lat = i; s_dqdone = ram_dq_oe;
      end
    end
    if (!got) check("ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (!p) u_m0.req = 1'b0;
    else    u_m1.req = 1'b0;
  endtask

  int ack_port [4];
  int ack_cyc  [4];
  int n_ack;

  initial begin
    {u_m0.req, u_m0.we, u_m0.a, u_m0.wdata} = '0;
    {u_m1.req, u_m1.we, u_m1.a, u_m1.wdata} = '0;
    {u_a1.req, u_a1.we, u_a1.a, u_a1.wdata} = '0;
    {u_b1.req, u_b1.we, u_b1.a, u_b1.wdata} = '0;
    {u_a15.req, u_a15.we, u_a15.a, u_a15.wdata} = '0;
    {u_b15.req, u_b15.we, u_b15.a, u_b15.wdata} = '0;

    #23;
    check("rst_ce_n",  ram_ce_n, 1);
    check("rst_oe_n",  ram_oe_n, 1);
    check("rst_we_n",  ram_we_n, 1);
    check("rst_lb_n",  ram_lb_n, 1);
    check("rst_ub_n",  ram_ub_n, 1);
    check("rst_dq_oe", ram_dq_oe, 0);
    check("rst_ack0",  u_m0.ack, 0);
    check("rst_ack1",  u_m1.ack, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_dout",  ram_dout, 0);
    check("rst_rd0",   u_m0.rdata, 0);
    check("rst_rd1",   u_m1.rdata, 0);
    check("zz_n",      ram_zz_n, 1);
    @(negedge clk); rst = 1'b0;

    // port 1 read, low lane
    din_ovr_en = 1'b1; din_ovr = 16'h3C5A;
    txn(1'b1, 1'b0, 23'h000010, 8'h00);
    din_ovr_en = 1'b0;
    check("rd_lat",    lat, 4);
    check("rd_ram_a",  s_a, 22'h000008);
    check("rd_ce_n",   s_ce, 0);
    check("rd_lb_n",   s_lb, 0);
    check("rd_ub_n",   s_ub, 1);
    check("rd_dq_oe",  s_dq, 0);
    check("rd_oe_cyc", oe_lo, 2);
    check("rd_we_cyc", we_lo, 0);
    check("rd_oth",    oth_ack, 0);
    check("rd_rd1",    u_m1.rdata, 8'h5A);
    check("rd_rd0",    u_m0.rdata, 8'h00);
    @(negedge clk);
    check("rd_ack_once", u_m1.ack, 0);

    // port 0 write, high lane
    txn(1'b0, 1'b1, 23'h000011, 8'hA5);
    check("wr_lat",    lat, 4);
    check("wr_ram_a",  s_a, 22'h000008);
    check("wr_ub_n",   s_ub, 0);
    check("wr_lb_n",   s_lb, 1);
    check("wr_dout",   s_dout, 16'hA5A5);
    check("wr_dq_oe",  s_dq, 1);
    check("wr_we_cyc", we_lo, 2);
    check("wr_oe_cyc", oe_lo, 0);
    check("wr_dq_done", s_dqdone, 1);
    check("wr_rd0",    u_m0.rdata, 8'h00);
    check("wr_rd1",    u_m1.rdata, 8'h5A);

    // read-after-write across ports
    txn(1'b1, 1'b1, 23'h000022, 8'h77);
    txn(1'b0, 1'b0, 23'h000022, 8'h00);
    check("raw_rd0", u_m0.rdata, 8'h77);
    txn(1'b0, 1'b0, 23'h000011, 8'h00);
    check("raw_hi",  u_m0.rdata, 8'hA5);

    // round robin from a fresh reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    u_m0.we = 1'b0; u_m0.a = 23'h000022; u_m0.req = 1'b1;
    u_m1.we = 1'b0; u_m1.a = 23'h000011; u_m1.req = 1'b1;
    @(posedge clk);
    n_ack = 0;
    for (int i = 1; i <= 60 && n_ack < 4; i++) begin
      @(negedge clk);
      if (u_m0.ack && u_m1.ack) check("rr_dual_ack", 1, 0);
      if (u_m0.ack || u_m1.ack) begin
        ack_port[n_ack] = u_m1.ack ? 1 : 0;
        ack_cyc[n_ack]  = i;
        n_ack++;
      end
    end
    @(posedge clk); #1;
    u_m0.req = 1'b0; u_m1.req = 1'b0;
    check("rr_count", n_ack, 4);
    if (n_ack == 4) begin
      check("rr_first", ack_cyc[0], 4);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_port%0d", k), ack_port[k], k % 2);
        if (k > 0)
          check($sformatf("rr_gap%0d", k),
                ack_cyc[k] - ack_cyc[k-1], 5);
      end
    end
    check("rr_rd0", u_m0.rdata, 8'h77);
    check("rr_rd1", u_m1.rdata, 8'hA5);

    // reset in the middle of a write
    @(posedge clk); #1;
    u_m0.we = 1'b1; u_m0.a = 23'h000030;
    u_m0.wdata = 8'h5C; u_m0.req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ab_in_access", ram_we_n, 0);
    #1 rst = 1'b1;
    #1;
    check("ab_ce_n",  ram_ce_n, 1);
    check("ab_we_n",  ram_we_n, 1);
    check("ab_dq_oe", ram_dq_oe, 0);
    check("ab_lb_n",  ram_lb_n, 1);
    check("ab_ub_n",  ram_ub_n, 1);
    u_m0.req = 1'b0;
    @(negedge clk); rst = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (u_m0.ack || u_m1.ack) n_ack++;
    end
    check("ab_no_ack", n_ack, 0);
    txn(1'b0, 1'b0, 23'h000022, 8'h00);
    check("ab_next_lat", lat, 4);
    check("ab_next_rd0", u_m0.rdata, 8'h77);

    // WAIT_CYC = 1
    @(posedge clk); #1;
    u_a1.we = 1'b0; u_a1.req = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (u_a1.ack) lat = i;
    end
    @(posedge clk); #1 u_a1.req = 1'b0;
    check("w1_lat", lat, 3);

    // WAIT_CYC = 15
    @(posedge clk); #1;
    u_a15.we = 1'b0; u_a15.req = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (u_a15.ack) lat = i;
    end
    @(posedge clk); #1 u_a15.req = 1'b0;
    check("w15_lat", lat, 17);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
